fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_pkg.sv | 24 ++
 rtl/uart_baud_cnt.sv | 42 ++++
 rtl/fifo_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

   localparam int   DATA_BITS = 8;
   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Parity of a data byte: XOR of all bits, inverted for odd sense.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                       input logic                 sense);
      return (^data) ^ sense;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, restarting on each bit
// boundary or whenever clr is held.  pre_tick marks the cycle before the
// boundary so the parent can line up registered outputs with it.
module uart_baud_cnt
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clock,
   input  logic rst,
   input  logic clr,
   output logic bit_tick,
   output logic pre_tick
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

   logic [CW-1:0] cnt_q, cnt_d;

   assign bit_tick = (cnt_q == CNT_LAST);
   assign pre_tick = (cnt_q == CNT_PRE);

   // Next count: wrap to zero at a bit boundary or while cleared.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || bit_tick) begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer that serialises each byte onto a UART line:
// start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All outputs are registered from next-state values so they line up
// with the state register.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clock,
   input  logic                 rst,
   input  logic                 tx_en,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_data,
   output logic                 fifo_rd,
   output logic                 tx,
   output logic                 busy,
   output logic                 byte_done,
   output logic [15:0]          tx_count
);

   localparam logic       SENSE    = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 rd_q, rd_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [15:0]          tx_count_q, tx_count_d;

   logic baud_clr;
   logic bit_tick;
   logic pre_tick;
   logic last_stop;
   logic next_frame;

   // A second stop bit exists only when STOP_BITS is 2.
   assign last_stop  = (STOP_BITS == 2) ? stop_idx_q : 1'b1;
   assign next_frame = tx_en && !fifo_empty;

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clock   (clock),
      .rst     (rst),
      .clr     (baud_clr),
      .bit_tick(bit_tick),
      .pre_tick(pre_tick)
   );

   // Next-state logic plus registered-output precomputation.
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      par_d      = par_q;
      tx_count_d = tx_count_q;
      done_d     = 1'b0;
      baud_clr   = 1'b0;
      tx_d       = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            baud_clr = 1'b1;
            if (next_frame) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            baud_clr = 1'b1;
            state_d  = ST_LOAD;
         end
         ST_LOAD: begin
            // FIFO data is valid now, one cycle after the read strobe.
            baud_clr   = 1'b1;
            shreg_d    = fifo_data;
            par_d      = parity_bit(fifo_data, SENSE);
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            state_d    = ST_START;
         end
         ST_START: begin
            if (bit_tick) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               shreg_d   = {1'b0, shreg_q[DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == LAST_BIT) begin
                  state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end
            end
         end
         ST_PARITY: begin
            if (bit_tick) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            // Raise byte_done and bump the count so both show on the
            // final stop cycle.
            if (pre_tick && last_stop) begin
               done_d     = 1'b1;
               tx_count_d = tx_count_q + 16'd1;
            end
            if (bit_tick) begin
               if (last_stop) begin
                  state_d = next_frame ? ST_FETCH : ST_IDLE;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      unique case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shreg_d[0];
         ST_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase

      rd_d   = (state_d == ST_FETCH);
      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and output registers.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         shreg_q    <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
         rd_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tx_count_q <= '0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
         rd_q       <= rd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tx_count_q <= tx_count_d;
      end
   end

   assign tx        = tx_q;
   assign fifo_rd   = rd_q;
   assign busy      = busy_q;
   assign byte_done = done_q;
   assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: three transmitters (no parity / even parity + 2 stop /
// odd parity + 2 stop) fed by behavioural FIFOs; a monitor per instance
// decodes each frame and compares it with the queued expectation.
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic rst;
   logic tx_en;

   wire  [2:0]  tx_w, rd_w, busy_w, bd_w;
   wire  [15:0] cnt_w [3];
   logic [7:0]  fdata [3] = '{8'h00, 8'h00, 8'h00};
   logic [2:0]  fempty = 3'b111;

   logic [7:0] fq0[$], fq1[$], fq2[$];
   exp_t       ex0[$], ex1[$], ex2[$];

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   rd_cnt [3] = '{0, 0, 0};
   int   bd_cnt [3] = '{0, 0, 0};
   int   frames [3] = '{0, 0, 0};
   int   gap    [3] = '{-1, -1, -1};
   logic last_par [3] = '{1'b0, 1'b0, 1'b0};

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_a (
      .clock(clock), .rst(rst), .tx_en(tx_en), .fifo_empty(fempty[0]), .fifo_data(fdata[0]),
      .fifo_rd(rd_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .byte_done(bd_w[0]), .tx_count(cnt_w[0]));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_b (
      .clock(clock), .rst(rst), .tx_en(tx_en), .fifo_empty(fempty[1]), .fifo_data(fdata[1]),
      .fifo_rd(rd_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .byte_done(bd_w[1]), .tx_count(cnt_w[1]));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut_c (
      .clock(clock), .rst(rst), .tx_en(tx_en), .fifo_empty(fempty[2]), .fifo_data(fdata[2]),
      .fifo_rd(rd_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .byte_done(bd_w[2]), .tx_count(cnt_w[2]));

   // Cycle counter for gap measurement.
   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural FIFOs: data appears the cycle after a read strobe.
   always @(posedge clock) begin
      if (rd_w[0] && fq0.size() > 0) fdata[0] <= fq0.pop_front();
      if (rd_w[1] && fq1.size() > 0) fdata[1] <= fq1.pop_front();
      if (rd_w[2] && fq2.size() > 0) fdata[2] <= fq2.pop_front();
      fempty[0] <= (fq0.size() == 0);
      fempty[1] <= (fq1.size() == 0);
      fempty[2] <= (fq2.size() == 0);
   end

   // Pulse counters for read strobes and byte_done.
   always @(negedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (rd_w[i]) rd_cnt[i] <= rd_cnt[i] + 1;
         if (bd_w[i]) bd_cnt[i] <= bd_cnt[i] + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int i, input logic [7:0] d, input logic p);
      exp_t e;
      e.d = d;
      e.p = p;
      case (i)
         0: begin fq0.push_back(d); ex0.push_back(e); end
         1: begin fq1.push_back(d); ex1.push_back(e); end
         default: begin fq2.push_back(d); ex2.push_back(e); end
      endcase
   endtask

   function automatic int exp_size(input int i);
      case (i)
         0: return ex0.size();
         1: return ex1.size();
         default: return ex2.size();
      endcase
   endfunction

   function automatic exp_t pop_exp(input int i);
      case (i)
         0: return ex0.pop_front();
         1: return ex1.pop_front();
         default: return ex2.pop_front();
      endcase
   endfunction

   // Expected line waveform (one entry per clock) for a given frame.
   function automatic void build(input int i, input exp_t e, output logic [63:0] w,
                                 output logic [63:0] bd, output int len);
      int   pe = (i > 0) ? 1 : 0;
      int   sb = (i > 0) ? 2 : 1;
      int   nb = 10 + pe + sb - 1;
      logic b;
      w = '0;
      for (int n = 0; n < nb; n++) begin
         if (n == 0)                b = 1'b0;
         else if (n <= 8)           b = e.d[n-1];
         else if (n == 9 && pe == 1) b = e.p;
         else                       b = 1'b1;
         for (int k = 0; k < CPB; k++) w[n*CPB + k] = b;
      end
      len = nb * CPB;
      bd  = 64'd1 << (len - 1);
   endfunction

   task automatic monitor(input int i);
      logic [63:0] w_act, bd_act, w_exp, bd_exp;
      int          len;
      exp_t        e;
      int          exp_cnt   = 0;
      bit          have_prev = 0;
      int          prev_end  = 0;
      bit          abort;
      bit          got;
      forever begin
         @(negedge clock);
         if (!rst) begin
            exp_cnt   = 0;
            have_prev = 0;
         end else if (tx_w[i] == 1'b0) begin
            got = (exp_size(i) > 0);
            e   = got ? pop_exp(i) : '0;
            build(i, e, w_exp, bd_exp, len);
            if (have_prev) gap[i] = cyc - prev_end - 1;
            w_act     = '0;
            bd_act    = '0;
            abort     = 0;
            w_act[0]  = tx_w[i];
            bd_act[0] = bd_w[i];
            for (int k = 1; k < len && !abort; k++) begin
               @(negedge clock);
               if (!rst) abort = 1;
               else begin
                  w_act[k]  = tx_w[i];
                  bd_act[k] = bd_w[i];
               end
            end
            if (abort) begin
               exp_cnt   = 0;
               have_prev = 0;
            end else begin
               check($sformatf("frame_expected%0d", i), 64'(got), 64'd1);
               check($sformatf("wave%0d_byte%02h", i, e.d), w_act, w_exp);
               check($sformatf("byte_done%0d", i), bd_act, bd_exp);
               exp_cnt = (exp_cnt + 1) & 16'hFFFF;
               check($sformatf("tx_count%0d", i), 64'(cnt_w[i]), 64'(exp_cnt));
               if (i > 0) last_par[i] = w_act[9*CPB + CPB/2];
               frames[i]++;
               prev_end  = cyc;
               have_prev = 1;
            end
         end
      end
   endtask

   task automatic wait_frames(input int i, input int n, input int maxc, input string name);
      int c = 0;
      while (frames[i] < n && c < maxc) begin
         @(negedge clock);
         c++;
      end
      check(name, 64'(frames[i] >= n), 64'd1);
      repeat (2) @(negedge clock);
   endtask

   task automatic wait_start(input int i, input int maxc, input string name);
      int c = 0;
      @(negedge clock);
      while (tx_w[i] !== 1'b0 && c < maxc) begin
         @(negedge clock);
         c++;
      end
      check(name, 64'(tx_w[i]), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #1 rst = 1'b0;
      repeat (3) @(negedge clock);
      #1 rst = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int rb, bb, fb, fb1, fb2;
      rst   = 1'b0;
      tx_en = 1'b0;
      fork
         monitor(0);
         monitor(1);
         monitor(2);
      join_none
      repeat (3) @(negedge clock);
      #1 rst = 1'b1;

      // 1: reset mid-frame, release with FIFO empty
      push(0, 8'h3C, 1'b0);
      tx_en = 1'b1;
      wait_start(0, 20, "t1_start");
      repeat (10) @(negedge clock);
      #1 rst = 1'b0;
      #1 check("t1_tx_async", 64'(tx_w[0]), 64'd1);
      repeat (2) @(negedge clock);
      check("t1_rd", 64'(rd_w[0]), 64'd0);
      check("t1_busy", 64'(busy_w[0]), 64'd0);
      check("t1_byte_done", 64'(bd_w[0]), 64'd0);
      check("t1_count", 64'(cnt_w[0]), 64'd0);
      #1 rst = 1'b1;
      rb = rd_cnt[0];
      repeat (100) @(negedge clock);
      check("t1_no_rd", 64'(rd_cnt[0] - rb), 64'd0);
      check("t1_idle_tx", 64'(tx_w[0]), 64'd1);

      // 2: single byte 0xA5
      do_reset();
      rb = rd_cnt[0]; bb = bd_cnt[0]; fb = frames[0];
      push(0, 8'hA5, 1'b0);
      wait_frames(0, fb + 1, 200, "t2_timeout");
      check("t2_rd_pulses", 64'(rd_cnt[0] - rb), 64'd1);
      check("t2_done_pulses", 64'(bd_cnt[0] - bb), 64'd1);
      check("t2_count", 64'(cnt_w[0]), 64'd1);
      check("t2_busy", 64'(busy_w[0]), 64'd0);

      // 3: back-to-back 0x00, 0xFF
      do_reset();
      gap[0] = -1;
      rb = rd_cnt[0]; fb = frames[0];
      push(0, 8'h00, 1'b0);
      push(0, 8'hFF, 1'b0);
      wait_frames(0, fb + 2, 400, "t3_timeout");
      check("t3_gap", 64'(gap[0]), 64'd2);
      check("t3_count", 64'(cnt_w[0]), 64'd2);
      check("t3_rd_pulses", 64'(rd_cnt[0] - rb), 64'd2);

      // 4: parity 0x07, even -> 1, odd -> 0, two stop bits
      do_reset();
      fb1 = frames[1]; fb2 = frames[2];
      push(1, 8'h07, 1'b1);
      push(2, 8'h07, 1'b0);
      wait_frames(1, fb1 + 1, 200, "t4_even_timeout");
      wait_frames(2, fb2 + 1, 200, "t4_odd_timeout");
      check("t4_par_even", 64'(last_par[1]), 64'd1);
      check("t4_par_odd", 64'(last_par[2]), 64'd0);

      // 5: drop tx_en mid-frame, then resume
      do_reset();
      rb = rd_cnt[0]; fb = frames[0];
      push(0, 8'h11, 1'b0);
      push(0, 8'h22, 1'b0);
      push(0, 8'h33, 1'b0);
      wait_start(0, 20, "t5_start");
      repeat (12) @(negedge clock);
      #1 tx_en = 1'b0;
      wait_frames(0, fb + 1, 200, "t5_first_timeout");
      repeat (20) @(negedge clock);
      check("t5_rd_paused", 64'(rd_cnt[0] - rb), 64'd1);
      check("t5_busy_paused", 64'(busy_w[0]), 64'd0);
      check("t5_count_paused", 64'(cnt_w[0]), 64'd1);
      #1 tx_en = 1'b1;
      wait_frames(0, fb + 3, 300, "t5_rest_timeout");
      check("t5_rd_total", 64'(rd_cnt[0] - rb), 64'd3);
      check("t5_count", 64'(cnt_w[0]), 64'd3);

      // 6: reset during data bit 3, next byte sent intact
      do_reset();
      fb = frames[0];
      push(0, 8'hC3, 1'b0);
      push(0, 8'h5A, 1'b0);
      wait_start(0, 20, "t6_start");
      repeat (17) @(negedge clock);
      check("t6_tx_bit3", 64'(tx_w[0]), 64'd0);
      check("t6_count_before", 64'(cnt_w[0]), 64'd0);
      #1 rst = 1'b0;
      #1 check("t6_tx_async", 64'(tx_w[0]), 64'd1);
      check("t6_count_reset", 64'(cnt_w[0]), 64'd0);
      repeat (2) @(negedge clock);
      #1 rst = 1'b1;
      wait_frames(0, fb + 1, 200, "t6_timeout");
      check("t6_count_after", 64'(cnt_w[0]), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
